btn_input_port: RTL

Input conditioner for the 16 slide-switch/button lines feeding the datapath's button inputs (high and low bytes). It synchronises the raw asynchronous switches to `clock`, debounces the whole 16-bit vector with one shared settle counter, and presents stable high/low bytes to the datapath. It also raises a `changed` status flag that the controller polls and clears through read strobes. It is the input-side counterpart of the LED output registers.

---
 rtl/btn_input_port_if.sv | 73 +++++++
 rtl/btn_input_port.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/btn_input_port_if.sv
// -----------------------------------------------------------------------------
// btn_input_port_if
//
// Bundles the switch/button conditioner's data and status signals so the
// conditioner and its controller share one port.
//
//   swIn      [15:0]  raw switch lines, asynchronous to the system clock
//   rdH               controller read strobe for the high byte (one cycle)
//   rdL               controller read strobe for the low byte (one cycle)
//   BTNHDout  [7:0]   debounced stable bits [15:8]
//   BTNLDout  [7:0]   debounced stable bits [7:0]
//   changed           sticky "stable vector changed since last read" flag
//   edgeH     [7:0]   sticky rising-edge bits [15:8]  (BTN_EDGE_LATCH_EN only)
//   edgeL     [7:0]   sticky rising-edge bits [7:0]   (BTN_EDGE_LATCH_EN only)
//
// Modports:
//   slave   - the conditioner (drives the debounced outputs)
//   master  - the controller / switch side (drives swIn and the read strobes)
//
// Optional feature macro: BTN_EDGE_LATCH_EN adds the edgeH/edgeL signals.
// -----------------------------------------------------------------------------
interface btn_input_port_if;
   logic [15:0] swIn;
   logic        rdH;
   logic        rdL;
   logic [7:0]  BTNHDout;
   logic [7:0]  BTNLDout;
   logic        changed;
`ifdef BTN_EDGE_LATCH_EN
   logic [7:0]  edgeH;
   logic [7:0]  edgeL;

   modport slave (
      input  swIn,
      input  rdH,
      input  rdL,
      output BTNHDout,
      output BTNLDout,
      output changed,
      output edgeH,
      output edgeL
   );

   modport master (
      output swIn,
      output rdH,
      output rdL,
      input  BTNHDout,
      input  BTNLDout,
      input  changed,
      input  edgeH,
      input  edgeL
   );
`else
   modport slave (
      input  swIn,
      input  rdH,
      input  rdL,
      output BTNHDout,
      output BTNLDout,
      output changed
   );

   modport master (
      output swIn,
      output rdH,
      output rdL,
      input  BTNHDout,
      input  BTNLDout,
      input  changed
   );
`endif
endinterface : btn_input_port_if

// File: rtl/btn_input_port.sv
// -----------------------------------------------------------------------------
// btn_input_port
//
// Input conditioner for the 16 slide-switch/button lines. The raw lines are
// brought into the clock domain through a two-flop synchroniser, the whole
// 16-bit vector is debounced with a single shared settle counter, and the
// settled value is presented as a high and a low byte. A sticky "changed"
// flag tells the polling controller that the stable vector moved; either
// read strobe clears it.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive cycles the synchronised vector must hold
//                    before it is committed (2..65535, default 16)
//
// Ports:
//   clock   system clock, all state changes on the rising edge
//   nRst    asynchronous active-low reset
//   bus     btn_input_port_if.slave (swIn, rdH, rdL in; BTNHDout, BTNLDout,
//           changed and optionally edgeH/edgeL out)
//
// Optional feature macro: BTN_EDGE_LATCH_EN
//   When defined, sticky rising-edge registers edgeH/edgeL are built. At every
//   commit they accumulate bits that went 0->1; rdH clears edgeH, rdL clears
//   edgeL, and edges discovered in the same cycle as a clear survive it.
//
// Latency: a swIn change sampled at edge k lands in the outputs at edge
// k+2+DEBOUNCE_CYCLES and raises "changed" at edge k+3+DEBOUNCE_CYCLES.
// -----------------------------------------------------------------------------
module btn_input_port #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic              clock,
   input  logic              nRst,
   btn_input_port_if.slave   bus
);

   // Counter is just wide enough to hold DEBOUNCE_CYCLES-1.
   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [15:0]      s1_q;
   logic [15:0]      s2_q;
   logic [15:0]      cand_q;
   logic [15:0]      cand_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [15:0]      stable_q;
   logic [15:0]      stable_d;
   logic             diff_q;
   logic             diff_d;
   logic             changed_q;
   logic             changed_d;

   // Combinational helpers
   logic             commit;
   logic             rd_any;
   logic [15:0]      rise;

   // ------------------------------------------------------------------
   // Two-flop synchroniser. Nothing downstream looks at s1_q, so
   // metastability has a full cycle to resolve before it is used.
   // ------------------------------------------------------------------
   always_ff @(posedge clock or negedge nRst) begin
      if (!nRst) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= bus.swIn;
         s2_q <= s1_q;
      end
   end

   // ------------------------------------------------------------------
   // Shared debounce: any difference on any bit reloads the candidate
   // and restarts the window for the whole vector. Once the counter
   // saturates at CNT_LAST the candidate is committed every cycle; these
   // repeated commits are harmless because stable already equals cand.
   // ------------------------------------------------------------------
   always_comb begin
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      stable_d = stable_q;
      commit   = 1'b0;

      if (s2_q != cand_q) begin
         cand_d = s2_q;
         cnt_d  = '0;
      end else if (cnt_q != CNT_LAST) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         stable_d = cand_q;
         commit   = 1'b1;
      end
   end

   // Rising bits of the vector being committed this cycle (zero otherwise).
   assign rise = commit ? (cand_q & ~stable_q) : 16'h0000;

   // ------------------------------------------------------------------
   // Changed flag. diff_q marks "a commit just altered stable"; it feeds
   // the sticky flag one edge later. Setting has priority over the read
   // clear so a commit that races a read is never lost.
   // ------------------------------------------------------------------
   assign rd_any = bus.rdH | bus.rdL;

   always_comb begin
      diff_d    = commit && (cand_q != stable_q);
      changed_d = diff_q | (changed_q & ~rd_any);
   end

   always_ff @(posedge clock or negedge nRst) begin
      if (!nRst) begin
         cand_q    <= '0;
         cnt_q     <= '0;
         stable_q  <= '0;
         diff_q    <= 1'b0;
         changed_q <= 1'b0;
      end else begin
         cand_q    <= cand_d;
         cnt_q     <= cnt_d;
         stable_q  <= stable_d;
         diff_q    <= diff_d;
         changed_q <= changed_d;
      end
   end

   // Outputs come straight from flops; there is no path from swIn.
   assign bus.BTNHDout = stable_q[15:8];
   assign bus.BTNLDout = stable_q[7:0];
   assign bus.changed  = changed_q;

`ifdef BTN_EDGE_LATCH_EN
   // ------------------------------------------------------------------
   // Sticky rising-edge latches. The clear removes only the bits already
   // held; edges found in the same cycle are OR-ed in after the clear.
   // ------------------------------------------------------------------
   logic [7:0] edge_h_q;
   logic [7:0] edge_h_d;
   logic [7:0] edge_l_q;
   logic [7:0] edge_l_d;

   always_comb begin
      edge_h_d = (bus.rdH ? 8'h00 : edge_h_q) | rise[15:8];
      edge_l_d = (bus.rdL ? 8'h00 : edge_l_q) | rise[7:0];
   end

   always_ff @(posedge clock or negedge nRst) begin
      if (!nRst) begin
         edge_h_q <= '0;
         edge_l_q <= '0;
      end else begin
         edge_h_q <= edge_h_d;
         edge_l_q <= edge_l_d;
      end
   end

   assign bus.edgeH = edge_h_q;
   assign bus.edgeL = edge_l_q;
`else
   // Without the edge latches the rising-bit vector has no consumer.
   logic unused_rise;
   assign unused_rise = ^rise;
`endif

endmodule : btn_input_port
